encode_block: RTL
=================

# encode_block

Instruction encoder on the write side of the instruction FIFO. It accepts one instruction header plus 0-3 vertices over valid/ready handshakes and packs them into one 82-bit FIFO word. It writes that word once the FIFO has room. The word layout is exactly the one decode_block unpacks on the read side.

## Interface
- COORD_W, 8, bits per x or y coordinate
- MAX_VERTS, 3, vertices per instruction; FIFO_W = 34 + 2*COORD_W*MAX_VERTS (82 at defaults; only defaults are supported for decode_block compatibility)

- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- hdr_valid  in  1  header offered
- hdr_ready  out  1  header accepted when valid&ready
- inst_type  in  1  instruction type
- fill_type  in  1  fill type
- layer_num  in  2  target layer
- texture_code  in  2  texture select
- color_code  in  24  RGB colour
- vertice_num  in  2  vertex count, 0-3
- vtx_valid  in  1  vertex offered
- vtx_ready  out  1  vertex accepted when valid&ready
- vtx_x  in  COORD_W  vertex x
- vtx_y  in  COORD_W  vertex y
- fifo_full  in  1  FIFO cannot accept a write
- fifo_wenable  out  1  write strobe, one cycle per word
- fifo_data  out  82  packed word
- busy  out  1  high in any state other than IDLE

## Operation
- Word layout:
  - [81] inst_type
  - [80] fill_type
  - [79:78] layer_num
  - [77:76] texture_code
  - [75:52] color_code
  - [51:50] vertice_num
  - [49:48] reserved, always 0
  - [47:0] coordinates, vertex k in [16k+15:16k] as {x,y}
- Unused vertex slots are 0.
- FSM states: IDLE, VERTS, PUSH.
- IDLE:
  - hdr_ready=1, vtx_ready=0.
  - On the header handshake, register all header fields, clear the coordinate register and set vcnt=0.
  - Go to VERTS if vertice_num>0, else go to PUSH.
- VERTS:
  - vtx_ready=1, hdr_ready=0.
  - Each vertex handshake writes {vtx_x,vtx_y} to slot vcnt and increments vcnt.
  - The handshake with vcnt==vertice_num-1 goes to PUSH.
  - With vtx_valid low, stay in VERTS indefinitely.
- PUSH:
  - Both readies are 0.
  - fifo_wenable = !fifo_full, combinational from the state and fifo_full.
  - The write cycle returns the FSM to IDLE.
  - With fifo_full high, hold the state and keep fifo_data stable.
- Inputs offered in the wrong state are ignored: a header during VERTS/PUSH, or a vertex during IDLE/PUSH, is not consumed.
- fifo_data is driven from the registered fields in every state. It is valid for the FIFO only while fifo_wenable=1.
- vcnt is 2 bits and never wraps, because it is bounded by vertice_num ≤ 3.

## Timing
- Reset values: state=IDLE, all field and coordinate registers 0, vcnt=0.
- Reset values of outputs: fifo_data=0, fifo_wenable=0, hdr_ready=1, vtx_ready=0, busy=0.
- Reset mid-operation discards the partial instruction; no write occurs.
- Latency:
  - Header handshake at cycle t with n vertices offered back-to-back: vertices are accepted at t+1..t+n, and fifo_wenable is high at t+n+1 if the FIFO is not full.
  - With n=0, fifo_wenable is high at t+1.
- Throughput: at most one instruction per n+2 cycles. The next header is accepted at the cycle after the write.
- fifo_full rising in the same cycle the FSM enters PUSH delays the write; no word is lost or duplicated.
- Exactly one fifo_wenable pulse per accepted header.

## Structure
- Shared package gpu_pkg holds:
  - the field position localparams (INST_TYPE_BIT, FILL_TYPE_BIT, LAYER_LSB, TEX_LSB, COLOR_LSB, VNUM_LSB, COORD_LSB)
  - FIFO_W
  - enc_state_t {IDLE, VERTS, PUSH}
- decode_block is expected to move to the same package constants.
- Single module, no sub-module. The pack function lives in the package so the encoder and the decoder agree on the layout.

## Test plan
- Reset with n_rst=0 mid-VERTS (after 1 of 3 vertices) -> no fifo_wenable, all outputs at their reset values, hdr_ready=1 on release.
- Header inst_type=1, fill_type=0, layer_num=2, texture_code=1, color_code=24'hFF8000, vertice_num=3; vertices (10,20), (30,40), (50,60) back-to-back, fifo_full=0 -> single fifo_wenable at t+4 with fifo_data = {1'b1,1'b0,2'd2,2'd1,24'hFF8000,2'd3,2'b00,16'h323C,16'h1E28,16'h0A14}.
- vertice_num=0, color_code=24'h00FF00 -> fifo_wenable at t+1, coordinates field 0.
- vertice_num=2 with fifo_full=1 held for 5 cycles after entering PUSH -> fifo_wenable=0 and fifo_data stable during the hold, one pulse when fifo_full drops, coordinate slot 2 = 0.
- vtx_valid pulsed every 3rd cycle during VERTS, plus hdr_valid held high throughout -> vtx_ready only in VERTS, the second header is accepted only after the write, two words in order.
- Loopback through decode_block: 20 random instructions -> decoded fields match the stimulus for every word.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared layout constants and packing helper for the instruction FIFO word.
// encode_block packs with pack_word; decode_block unpacks with the same positions.
package gpu_pkg;

  localparam int VTX_COORD_W = 8;
  localparam int VTX_SLOTS   = 3;
  localparam int SLOT_W      = 2 * VTX_COORD_W;
  localparam int COORDS_W    = SLOT_W * VTX_SLOTS;
  localparam int FIFO_W      = 34 + COORDS_W;

  localparam int INST_TYPE_BIT = FIFO_W - 1;
  localparam int FILL_TYPE_BIT = FIFO_W - 2;
  localparam int LAYER_LSB     = FIFO_W - 4;
  localparam int TEX_LSB       = FIFO_W - 6;
  localparam int COLOR_LSB     = FIFO_W - 30;
  localparam int VNUM_LSB      = FIFO_W - 32;
  localparam int COORD_LSB     = 0;

  typedef enum logic [1:0] {IDLE, VERTS, PUSH} enc_state_t;

  typedef struct packed {
    logic        inst_type;
    logic        fill_type;
    logic [1:0]  layer_num;
    logic [1:0]  texture_code;
    logic [23:0] color_code;
    logic [1:0]  vertice_num;
  } enc_hdr_t;

  // Bits [VNUM_LSB-1:COORDS_W] are reserved and stay zero.
  function automatic logic [FIFO_W-1:0] pack_word(input enc_hdr_t h,
                                                  input logic [COORDS_W-1:0] coords);
    logic [FIFO_W-1:0] w;
    w = '0;
    w[INST_TYPE_BIT]        = h.inst_type;
    w[FILL_TYPE_BIT]        = h.fill_type;
    w[LAYER_LSB +: 2]       = h.layer_num;
    w[TEX_LSB +: 2]         = h.texture_code;
    w[COLOR_LSB +: 24]      = h.color_code;
    w[VNUM_LSB +: 2]        = h.vertice_num;
    w[COORD_LSB +: COORDS_W] = coords;
    return w;
  endfunction

endpackage

// File: rtl/encode_block.sv
// Instruction encoder: collects a header plus 0-3 vertices over valid/ready
// and writes one packed word into the instruction FIFO when it has room.
module encode_block
  import gpu_pkg::*;
#(
  parameter int COORD_W   = VTX_COORD_W,
  parameter int MAX_VERTS = VTX_SLOTS
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              hdr_valid,
  output logic              hdr_ready,
  input  logic              inst_type,
  input  logic              fill_type,
  input  logic [1:0]        layer_num,
  input  logic [1:0]        texture_code,
  input  logic [23:0]       color_code,
  input  logic [1:0]        vertice_num,
  input  logic              vtx_valid,
  output logic              vtx_ready,
  input  logic [COORD_W-1:0] vtx_x,
  input  logic [COORD_W-1:0] vtx_y,
  input  logic              fifo_full,
  output logic              fifo_wenable,
  output logic [FIFO_W-1:0] fifo_data,
  output logic              busy
);

  localparam int VSLOT_W = 2 * COORD_W;
  localparam int CRD_W   = VSLOT_W * MAX_VERTS;

  enc_state_t       state_q, state_d;
  enc_hdr_t         hdr_q, hdr_d;
  logic [CRD_W-1:0] coords_q, coords_d;
  logic [1:0]       vcnt_q, vcnt_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      hdr_q    <= '0;
      coords_q <= '0;
      vcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      coords_q <= coords_d;
      vcnt_q   <= vcnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    coords_d     = coords_q;
    vcnt_d       = vcnt_q;
    hdr_ready    = 1'b0;
    vtx_ready    = 1'b0;
    fifo_wenable = 1'b0;
    unique case (state_q)
      IDLE: begin
        hdr_ready = 1'b1;
        if (hdr_valid) begin
          hdr_d.inst_type    = inst_type;
          hdr_d.fill_type    = fill_type;
          hdr_d.layer_num    = layer_num;
          hdr_d.texture_code = texture_code;
          hdr_d.color_code   = color_code;
          hdr_d.vertice_num  = vertice_num;
          coords_d           = '0;
          vcnt_d             = '0;
          state_d            = (vertice_num != 2'd0) ? VERTS : PUSH;
        end
      end
      VERTS: begin
        vtx_ready = 1'b1;
        if (vtx_valid) begin
          for (int k = 0; k < MAX_VERTS; k++) begin
            if (vcnt_q == 2'(k)) coords_d[k*VSLOT_W +: VSLOT_W] = {vtx_x, vtx_y};
          end
          vcnt_d = vcnt_q + 2'd1;
          if (vcnt_q == hdr_q.vertice_num - 2'd1) state_d = PUSH;
        end
      end
      PUSH: begin
        // Write strobe is combinational so a full FIFO stalls without losing a cycle.
        fifo_wenable = !fifo_full;
        if (!fifo_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_data = pack_word(hdr_q, coords_q);
  assign busy      = (state_q != IDLE);

endmodule
